decode_regread: RTL

Decode-stage register read unit for the Y86-64 SEQ core; the read-side counterpart of the write-back stage. It owns the 15-entry × 64-bit architectural register file. It derives srcA/srcB from the fetched instruction fields, reads both operands, and presents them to execute through a registered valid/ready output stage. Write-back commits arrive on a dual-destination write port (E and M), so the register file has one writer and one reader in a single block.

---
 rtl/decode_regread.sv | 79 +++++++
 1 files changed

// File: rtl/decode_regread.sv
// decode_regread: Y86-64 decode register read with dual-port write-back and registered valid/ready output; REGFILE_BYPASS_EN selects write-before-read.
module decode_regread (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_code,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        wb_en_e,
  input  logic [3:0]  wb_dst_e,
  input  logic [63:0] wb_val_e,
  input  logic        wb_en_m,
  input  logic [3:0]  wb_dst_m,
  input  logic [63:0] wb_val_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_code,
  output logic [3:0]  out_src_a,
  output logic [3:0]  out_src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic [63:0] rf [15];
  logic [3:0] src_a, src_b;
  logic [63:0] rd_a, rd_b;
  logic accept;
  function automatic logic [63:0] rd(input logic [3:0] id);
`ifdef REGFILE_BYPASS_EN
    rd = id == 4'hf ? 64'h0 :
         wb_en_m && wb_dst_m == id ? wb_val_m :
         wb_en_e && wb_dst_e == id ? wb_val_e : rf[id];
`else
    rd = id == 4'hf ? 64'h0 : rf[id];
`endif
  endfunction
  always_comb begin
    src_a = (in_code == 4'd2 || in_code == 4'd4 || in_code == 4'd6 || in_code == 4'd10) ? ra :
            (in_code == 4'd9 || in_code == 4'd11) ? 4'd4 : 4'hf;
    src_b = (in_code == 4'd4 || in_code == 4'd5 || in_code == 4'd6) ? rb :
            (in_code >= 4'd8 && in_code <= 4'd11) ? 4'd4 : 4'hf;
    rd_a = rd(src_a);
    rd_b = rd(src_b);
  end
  assign out_valid = state == FULL;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  always_comb state_n = accept ? FULL : out_ready ? EMPTY : state;
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else state <= state_n;
  end
  // M is assigned after E so it wins on a shared destination
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (wb_en_e && wb_dst_e != 4'hf) rf[wb_dst_e] <= wb_val_e;
      if (wb_en_m && wb_dst_m != 4'hf) rf[wb_dst_m] <= wb_val_m;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_code <= '0;
      out_src_a <= 4'hf;
      out_src_b <= 4'hf;
      val_a <= '0;
      val_b <= '0;
    end else if (accept) begin
      out_code <= in_code;
      out_src_a <= src_a;
      out_src_b <= src_b;
      val_a <= rd_a;
      val_b <= rd_b;
    end
  end
endmodule
